// File: rtl/key_request_cipher.sv
// Key-request consumer: raises the shared flag line, latches round keys after a settle window,
// then runs a 3-round byte cipher. Optional decrypt path is enabled by KEY_REQUEST_CIPHER_DECRYPT_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for a byte; in_ready high
// S_REQ    | flag driven 1 for REQ_CYCLES cycles
// S_SETTLE | flag released; keys sampled on the final cycle
// S_ROUND0 | cipher round with first key
// S_ROUND1 | cipher round with second key
// S_ROUND2 | cipher round with third key; key-use counter decrements
// S_DONE   | result registered onto out_data with a one-cycle out_valid
module key_request_cipher #(
    parameter int REQ_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int REKEY_EVERY   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    inout  wire        flag,
    input  logic [7:0] K_0,
    input  logic [7:0] K_1,
    input  logic [7:0] K_2,
`ifdef KEY_REQUEST_CIPHER_DECRYPT_EN
    input  logic       mode,
`endif
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_SETTLE,
        S_ROUND0,
        S_ROUND1,
        S_ROUND2,
        S_DONE
    } state_t;

    state_t     r_state;
    logic [7:0] r_timer;
    logic [7:0] r_use_cnt;
    logic [7:0] r_k0;
    logic [7:0] r_k1;
    logic [7:0] r_k2;
    logic [7:0] r_s;
    logic       r_flag_drv;
    logic       r_out_valid;
    logic [7:0] r_out_data;
`ifdef KEY_REQUEST_CIPHER_DECRYPT_EN
    logic       r_mode;
`endif

    logic [1:0] w_round_idx;
    logic [7:0] w_round_key;
    logic [7:0] w_round_out;

    function automatic logic [7:0] rotl3(input logic [7:0] x);
        return {x[4:0], x[7:5]};
    endfunction

    function automatic logic [7:0] rotr3(input logic [7:0] x);
        return {x[2:0], x[7:3]};
    endfunction

    // Decrypt walks the key schedule backwards and inverts each round.
    always_comb begin
        w_round_idx = 2'd0;
        case (r_state)
            S_ROUND1: w_round_idx = 2'd1;
            S_ROUND2: w_round_idx = 2'd2;
            default:  w_round_idx = 2'd0;
        endcase
`ifdef KEY_REQUEST_CIPHER_DECRYPT_EN
        if (r_mode) w_round_idx = 2'd2 - w_round_idx;
`endif
        case (w_round_idx)
            2'd0:    w_round_key = r_k0;
            2'd1:    w_round_key = r_k1;
            default: w_round_key = r_k2;
        endcase
        w_round_out = rotl3(r_s ^ w_round_key) + w_round_key;
`ifdef KEY_REQUEST_CIPHER_DECRYPT_EN
        if (r_mode) w_round_out = rotr3(r_s - w_round_key) ^ w_round_key;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_timer     <= 8'd0;
            r_use_cnt   <= 8'd0;
            r_k0        <= 8'd0;
            r_k1        <= 8'd0;
            r_k2        <= 8'd0;
            r_s         <= 8'd0;
            r_flag_drv  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'd0;
`ifdef KEY_REQUEST_CIPHER_DECRYPT_EN
            r_mode      <= 1'b0;
`endif
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_s <= in_data;
`ifdef KEY_REQUEST_CIPHER_DECRYPT_EN
                        r_mode <= mode;
`endif
                        if (r_use_cnt == 8'd0) begin
                            r_state    <= S_REQ;
                            r_flag_drv <= 1'b1;
                            r_timer    <= 8'(REQ_CYCLES - 1);
                        end else begin
                            r_state <= S_ROUND0;
                        end
                    end
                end
                S_REQ: begin
                    if (r_timer == 8'd0) begin
                        r_flag_drv <= 1'b0;
                        r_state    <= S_SETTLE;
                        r_timer    <= 8'(SETTLE_CYCLES - 1);
                    end else begin
                        r_timer <= r_timer - 8'd1;
                    end
                end
                S_SETTLE: begin
                    if (r_timer == 8'd0) begin
                        r_k0      <= K_0;
                        r_k1      <= K_1;
                        r_k2      <= K_2;
                        r_use_cnt <= 8'(REKEY_EVERY);
                        r_state   <= S_ROUND0;
                    end else begin
                        r_timer <= r_timer - 8'd1;
                    end
                end
                S_ROUND0: begin
                    r_s     <= w_round_out;
                    r_state <= S_ROUND1;
                end
                S_ROUND1: begin
                    r_s     <= w_round_out;
                    r_state <= S_ROUND2;
                end
                S_ROUND2: begin
                    r_s <= w_round_out;
                    if (r_use_cnt != 8'd0) r_use_cnt <= r_use_cnt - 8'd1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= r_s;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign flag      = r_flag_drv ? 1'b1 : 1'bz;
    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_key_request_cipher.sv
// Scoreboard bench for key_request_cipher: a default instance and a REKEY_EVERY=3 instance,
// each with its own expected-result queue checked by an independent monitor.
module tb_key_request_cipher;

    logic       clk;
    logic       rst_n;
    logic [7:0] k0, k1, k2;
    logic       mode;
    logic       iv0, iv1;
    logic [7:0] id0, id1;
    logic       ir0, ir1, ov0, ov1, bz0, bz1;
    logic [7:0] od0, od1;
    wire        flag0;
    wire        flag1;

    pulldown (flag0);
    pulldown (flag1);

    int cyc = 0;
    int pass_cnt = 0;
    int total_cnt = 0;
    int fc0 = 0;
    int fc1 = 0;

    typedef struct {
        logic [7:0] d;
        int         c;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    key_request_cipher u_dut0 (
        .clk(clk), .rst_n(rst_n), .flag(flag0),
        .K_0(k0), .K_1(k1), .K_2(k2),
`ifdef KEY_REQUEST_CIPHER_DECRYPT_EN
        .mode(mode),
`endif
        .in_valid(iv0), .in_data(id0), .in_ready(ir0),
        .out_valid(ov0), .out_data(od0), .busy(bz0)
    );

    key_request_cipher #(.REKEY_EVERY(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flag(flag1),
        .K_0(k0), .K_1(k1), .K_2(k2),
`ifdef KEY_REQUEST_CIPHER_DECRYPT_EN
        .mode(mode),
`endif
        .in_valid(iv1), .in_data(id1), .in_ready(ir1),
        .out_valid(ov1), .out_data(od1), .busy(bz1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (flag0 === 1'b1) fc0++;
        if (flag1 === 1'b1) fc1++;
        if (ov0 === 1'b1) begin
            if (q0.size() == 0) begin
                total_cnt++;
                $display("FAIL dut0 unexpected out_valid: data %0h at cycle %0d", od0, cyc);
            end else begin
                e = q0.pop_front();
                chk("dut0 out_data", {24'd0, od0}, {24'd0, e.d});
                chk("dut0 out_valid cycle", cyc, e.c);
            end
        end
        if (ov1 === 1'b1) begin
            if (q1.size() == 0) begin
                total_cnt++;
                $display("FAIL dut1 unexpected out_valid: data %0h at cycle %0d", od1, cyc);
            end else begin
                e = q1.pop_front();
                chk("dut1 out_data", {24'd0, od1}, {24'd0, e.d});
                chk("dut1 out_valid cycle", cyc, e.c);
            end
        end
    end

    // Called on a negedge; returns on the negedge right after the accepting edge.
    task automatic send(input int u, input logic [7:0] d, input int lat,
                        input logic [7:0] exp, input bit push);
        exp_t e;
        if (u == 0) begin
            chk("dut0 in_ready before send", {31'd0, ir0}, 32'd1);
            iv0 = 1'b1;
            id0 = d;
        end else begin
            chk("dut1 in_ready before send", {31'd0, ir1}, 32'd1);
            iv1 = 1'b1;
            id1 = d;
        end
        @(negedge clk);
        iv0 = 1'b0;
        iv1 = 1'b0;
        e.d = exp;
        e.c = cyc + lat;
        if (push) begin
            if (u == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    task automatic drain(input int u);
        int n = 0;
        while (n < 200 && ((u == 0) ? (q0.size() != 0 || bz0) : (q1.size() != 0 || bz1))) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total_cnt++;
            $display("FAIL drain dut%0d: still busy after %0d cycles", u, n);
        end
        @(negedge clk);
    endtask

    task automatic flag0_pattern(input string name);
        logic [11:0] pat;
        for (int i = 0; i < 12; i++) begin
            pat[i] = (flag0 === 1'b1);
            @(negedge clk);
        end
        chk(name, {20'd0, pat}, 32'h00F);
    endtask

    initial begin
        int f;
        rst_n = 1'b0;
        iv0 = 1'b0; iv1 = 1'b0;
        id0 = 8'd0; id1 = 8'd0;
        k0 = 8'd0; k1 = 8'd0; k2 = 8'd0;
        mode = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset in_ready", {31'd0, ir0}, 32'd1);
        chk("reset out_valid", {31'd0, ov0}, 32'd0);
        chk("reset out_data", {24'd0, od0}, 32'd0);
        chk("reset busy", {31'd0, bz0}, 32'd0);
        chk("reset flag released", {31'd0, flag0 === 1'b1}, 32'd0);
        chk("reset dut1 in_ready", {31'd0, ir1}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic vector with fresh key request and flag timing
        k0 = 8'h01; k1 = 8'h02; k2 = 8'h03;
        send(0, 8'h00, 16, 8'hCD, 1'b1);
        chk("busy after accept", {31'd0, bz0}, 32'd1);
        chk("in_ready low after accept", {31'd0, ir0}, 32'd0);
        flag0_pattern("flag0 request pattern");
        drain(0);
        repeat (3) @(negedge clk);
        chk("out_data holds", {24'd0, od0}, 32'hCD);

        // Carry drop in round 0; in_valid while busy must be ignored
        k0 = 8'hF0; k1 = 8'h00; k2 = 8'h00;
        send(0, 8'h00, 16, 8'hDD, 1'b1);
        iv0 = 1'b1; id0 = 8'h77;
        repeat (5) @(negedge clk);
        iv0 = 1'b0;
        drain(0);

        // Key change during ROUND1 has no effect
        k0 = 8'h01; k1 = 8'h02; k2 = 8'h03;
        send(0, 8'h00, 16, 8'hCD, 1'b1);
        repeat (13) @(negedge clk);
        k0 = 8'hFF; k1 = 8'hFF; k2 = 8'hFF;
        drain(0);
        k0 = 8'h01; k1 = 8'h02; k2 = 8'h03;

        // Reset in REQ cycle 2 aborts; next byte does a full request
        send(0, 8'h00, 16, 8'hCD, 1'b0);
        @(negedge clk);
        chk("flag high in REQ cycle 2", {31'd0, flag0 === 1'b1}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort flag released", {31'd0, flag0 === 1'b1}, 32'd0);
        chk("abort in_ready", {31'd0, ir0}, 32'd1);
        chk("abort busy", {31'd0, bz0}, 32'd0);
        chk("abort out_data cleared", {24'd0, od0}, 32'd0);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        send(0, 8'h5A, 16, 8'hA1, 1'b1);
        flag0_pattern("flag0 pattern after abort");
        drain(0);

        // REKEY_EVERY=3: one request covers three blocks
        f = fc1;
        send(1, 8'h00, 16, 8'hCD, 1'b1);
        drain(1);
        send(1, 8'h5A, 4, 8'hA1, 1'b1);
        drain(1);
        send(1, 8'h00, 4, 8'hCD, 1'b1);
        drain(1);
        chk("dut1 flag cycles for 3 blocks", fc1 - f, 32'd4);
        send(1, 8'h5A, 16, 8'hA1, 1'b1);
        drain(1);
        chk("dut1 flag cycles after 4th block", fc1 - f, 32'd8);

`ifdef KEY_REQUEST_CIPHER_DECRYPT_EN
        mode = 1'b1;
        send(0, 8'hCD, 16, 8'h00, 1'b1);
        drain(0);
        mode = 1'b0;
`endif

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
